// File: rtl/u41_denorm.sv
// -----------------------------------------------------------------------------
// u41_denorm
//
// Purpose:
//   Rebuilds an original 4-input truth table from a normalized one and the
//   input permutation that produced it. The request is captured on accept.
//   One entry is rebuilt per cycle over 16 BUSY cycles, and the result is
//   held until the consumer takes it.
//   Entry m of the result is
//       func[15-m] = norm[15-n],  bit j of n = bit (perm field j) of m
//   where perm field j is perm[7-2j:6-2j].
//   A perm whose fields are not all distinct is not a permutation. It skips
//   BUSY and goes straight to DONE with func = 0 and perm_err = 1.
//
// Handshake (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer holds valid and its data until that edge. The receiver may
//   raise or drop ready at will. in_ready is high only in IDLE and never
//   while rst is high. out_valid is high exactly while the result sits in
//   DONE. func and perm_err do not change while out_valid is high.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   in_valid     in   1   request valid
//   in_ready     out  1   block is idle and can accept a request
//   norm         in   16  normalized truth table, entry n at bit 15-n
//   perm         in   8   four 2-bit permutation fields
//   out_valid    out  1   func/perm_err hold a finished result
//   out_ready    in   1   consumer takes the result
//   func         out  16  rebuilt truth table, entry m at bit 15-m
//   perm_err     out  1   captured perm was not a permutation
//   o_dbg_state  out  2   FSM state (0 IDLE, 1 BUSY, 2 DONE) for observation
// -----------------------------------------------------------------------------
module u41_denorm (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] norm,
    input  logic [7:0]  perm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] func,
    output logic        perm_err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_norm;
    logic [7:0]  r_perm;
    logic [3:0]  r_m;
    logic [15:0] r_func;
    logic        r_perm_err;

    logic        w_perm_ok;
    logic [3:0]  w_n;
    logic [3:0]  w_norm_idx;
    logic [3:0]  w_func_idx;
    logic        w_bit;

    // Four 2-bit fields form a permutation exactly when no two are equal.
    assign w_perm_ok = (perm[7:6] != perm[5:4]) && (perm[7:6] != perm[3:2]) &&
                       (perm[7:6] != perm[1:0]) && (perm[5:4] != perm[3:2]) &&
                       (perm[5:4] != perm[1:0]) && (perm[3:2] != perm[1:0]);

    // Source index n for the current output entry m. Bit j of n is taken
    // from the bit of m that field j selects.
    assign w_n[0] = r_m[r_perm[7:6]];
    assign w_n[1] = r_m[r_perm[5:4]];
    assign w_n[2] = r_m[r_perm[3:2]];
    assign w_n[3] = r_m[r_perm[1:0]];

    // Entries are stored MSB-first, so entry k lives at bit 15-k.
    assign w_norm_idx = 4'd15 - w_n;
    assign w_func_idx = 4'd15 - r_m;
    assign w_bit      = r_norm[w_norm_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_norm     <= 16'h0000;
            r_perm     <= 8'h00;
            r_m        <= 4'd0;
            r_func     <= 16'h0000;
            r_perm_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_norm <= norm;
                        r_perm <= perm;
                        r_func <= 16'h0000;
                        r_m    <= 4'd0;
                        if (w_perm_ok) begin
                            r_perm_err <= 1'b0;
                            r_state    <= ST_BUSY;
                        end else begin
                            r_perm_err <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    r_func[w_func_idx] <= w_bit;
                    r_m                <= r_m + 4'd1;   // wraps to 0 after entry 15
                    if (r_m == 4'd15) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // func/perm_err keep their values into IDLE until the next accept.
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE) && !rst;
    assign out_valid   = (r_state == ST_DONE);
    assign func        = r_func;
    assign perm_err    = r_perm_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_u41_denorm.sv
// -----------------------------------------------------------------------------
// tb_u41_denorm
//   Bench for u41_denorm. It applies a table of directed vectors, then a
//   reset abort in mid-BUSY and in DONE, then random requests. Each expected
//   result is pushed to a queue when the request is accepted. It is popped
//   and compared when out_valid appears.
// -----------------------------------------------------------------------------
module tb_u41_denorm;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] norm;
    logic [7:0]  perm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] func;
    logic        perm_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] exp_q[$];   // {perm_err, func}

    typedef struct {
        logic [15:0] nm;
        logic [7:0]  pm;
        logic [15:0] f;
        logic        e;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    u41_denorm dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .norm        (norm),
        .perm        (perm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .func        (func),
        .perm_err    (perm_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model. It reads the mapping rule directly: for each output
    // entry m, build the source index n bit by bit from the permutation.
    function automatic logic [16:0] ref_model(input logic [15:0] nm, input logic [7:0] pm);
        int          fld[4];
        bit          seen[4];
        logic [15:0] res;
        int          n;
        res = 16'h0000;
        for (int j = 0; j < 4; j++) seen[j] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            fld[j] = (int'(pm) >> (6 - 2 * j)) & 3;
            if (seen[fld[j]]) return {1'b1, 16'h0000};
            seen[fld[j]] = 1'b1;
        end
        for (int m = 0; m < 16; m++) begin
            n = 0;
            for (int j = 0; j < 4; j++) begin
                if (((m >> fld[j]) & 1) == 1) n += (1 << j);
            end
            res[15 - m] = nm[15 - n];
        end
        return {1'b0, res};
    endfunction

    // One complete request/response. The DONE result is held for `hold`
    // cycles before the consumer takes it.
    task automatic run_op(input logic [15:0] nm, input logic [7:0] pm,
                          input logic [16:0] exp, input int hold);
        logic [16:0] want;
        int          lat;
        int          exp_lat;
        exp_lat = exp[16] ? 0 : 16;
        chk1("in_ready_idle", in_ready, 1'b1);
        norm     = nm;
        perm     = pm;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        norm     = 16'($urandom);
        perm     = 8'($urandom);
        lat      = 0;
        // While busy, toggle in_valid, out_ready and the data inputs at random.
        // The block must ignore all of them.
        while (!out_valid && lat < 40) begin
            chk1("in_ready_busy", in_ready, 1'b0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            norm      = 16'($urandom);
            perm      = 8'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chki("latency", lat, exp_lat);
        want = exp_q.pop_front();
        if (!out_valid) begin
            chk1("out_valid_timeout", out_valid, 1'b1);
            return;
        end
        chk16("func", func, want[15:0]);
        chk1("perm_err", perm_err, want[16]);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            tick();
            chk1("bp_out_valid", out_valid, 1'b1);
            chk16("bp_func_stable", func, want[15:0]);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("post_out_valid", out_valid, 1'b0);
        chk1("post_in_ready", in_ready, 1'b1);
        chk16("post_func_hold", func, want[15:0]);
        chk1("post_err_hold", perm_err, want[16]);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // ---------------- main test ----------------
    initial begin
        logic [7:0]  rp;
        logic [15:0] rn;
        int          a[4];
        int          k;
        int          t;

        vecs[0] = '{nm: 16'hA5C3, pm: 8'h1B, f: 16'hA5C3, e: 1'b0, hold: 0};  // identity
        vecs[1] = '{nm: 16'h2000, pm: 8'h4B, f: 16'h4000, e: 1'b0, hold: 1};  // swap low bits
        vecs[2] = '{nm: 16'h0800, pm: 8'h1E, f: 16'h0080, e: 1'b0, hold: 0};  // swap high bits
        vecs[3] = '{nm: 16'hFFFF, pm: 8'h1E, f: 16'hFFFF, e: 1'b0, hold: 2};
        vecs[4] = '{nm: 16'h1234, pm: 8'h00, f: 16'h0000, e: 1'b1, hold: 0};  // invalid perm
        vecs[5] = '{nm: 16'h8000, pm: 8'hE4, f: 16'h8000, e: 1'b0, hold: 0};  // reversed
        vecs[6] = '{nm: 16'h4000, pm: 8'hE4, f: 16'h0080, e: 1'b0, hold: 5};  // backpressure 5
        vecs[7] = '{nm: 16'hBEEF, pm: 8'h1A, f: 16'h0000, e: 1'b1, hold: 3};  // dup fields 2,3

        // reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        norm      = 16'h0000;
        perm      = 8'h00;
        tick();
        tick();
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_func", func, 16'h0000);
        chk1("rst_perm_err", perm_err, 1'b0);
        // reset wins over a request presented at the same edge
        in_valid = 1'b1;
        norm     = 16'hFFFF;
        perm     = 8'h00;
        tick();
        chk1("rst_prio_out_valid", out_valid, 1'b0);
        chk1("rst_prio_perm_err", perm_err, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk1("in_ready_after_rst", in_ready, 1'b1);

        // directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].nm, vecs[i].pm, {vecs[i].e, vecs[i].f}, vecs[i].hold);
        end

        // reset while BUSY with m == 7
        tick();
        norm     = 16'hF0F0;
        perm     = 8'h1B;
        in_valid = 1'b1;
        tick();                  // accept; m = 0
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();   // m = 7
        chk1("mid_busy_no_valid", out_valid, 1'b0);
        rst = 1'b1;
        tick();
        chk1("abort_out_valid", out_valid, 1'b0);
        chk16("abort_func", func, 16'h0000);
        chk1("abort_perm_err", perm_err, 1'b0);
        chk1("abort_in_ready_rst", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("abort_in_ready", in_ready, 1'b1);
        t = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid) t++;
        end
        chki("abort_no_stale", t, 0);

        // reset while DONE
        norm     = 16'h1111;
        perm     = 8'h55;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk1("done_err_valid", out_valid, 1'b1);
        chk1("done_err_flag", perm_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1("done_abort_out_valid", out_valid, 1'b0);
        chk1("done_abort_perm_err", perm_err, 1'b0);
        chk1("done_abort_in_ready", in_ready, 1'b1);
        tick();
        chk1("done_abort_still_idle", out_valid, 1'b0);

        // random requests against the reference model
        for (int i = 0; i < 30; i++) begin
            rn = 16'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                for (int j = 0; j < 4; j++) a[j] = j;
                for (int j = 3; j > 0; j--) begin
                    k    = $urandom_range(0, j);
                    t    = a[j];
                    a[j] = a[k];
                    a[k] = t;
                end
                rp = {2'(a[0]), 2'(a[1]), 2'(a[2]), 2'(a[3])};
            end else begin
                rp = 8'($urandom);
            end
            run_op(rn, rp, ref_model(rn, rp), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
